vector_elem_sequencer: RTL

Parametrised element sequencer for the vector unit. It sits between the vector decode stage and the lane datapath. On a start pulse it walks element indices from `vstart` to `vl-1`, issuing `NUM_LANES` element offsets per cycle with per-lane active masks. It also handles stall, flush and trap-driven capture of a restart `vstart`, and generalises the single-lane element counter to N lanes.

---
 rtl/vector_elem_sequencer_if.sv | 19 +
 rtl/vector_elem_sequencer.sv | 65 ++++++
 2 files changed

// File: rtl/vector_elem_sequencer_if.sv
// vector_elem_sequencer_if: decode-side control and lane-side group outputs of the element sequencer.
interface vector_elem_sequencer_if #(
   parameter int NUM_LANES = 2,
   parameter int VL_WIDTH  = 8
);
   logic                          start, stall, flush, trap;
   logic                          busy, valid, last, done;
   logic [VL_WIDTH-1:0]           vl, vstart, exc_vstart;
   logic [NUM_LANES*VL_WIDTH-1:0] offset;
   logic [NUM_LANES-1:0]          lane_active;
   modport master (
      output start, vl, vstart, stall, flush, trap,
      input  busy, valid, offset, lane_active, last, done, exc_vstart
   );
   modport slave (
      input  start, vl, vstart, stall, flush, trap,
      output busy, valid, offset, lane_active, last, done, exc_vstart
   );
endinterface

// File: rtl/vector_elem_sequencer.sv
// vector_elem_sequencer: walks element indices NUM_LANES per cycle with lane masks, stall/flush/trap.
// VSEQ_VSTART_EN enables a non-zero vstart and trap capture into exc_vstart.
module vector_elem_sequencer #(
   parameter int NUM_LANES = 2,
   parameter int VL_WIDTH  = 8
) (
   input logic                    CLK,
   input logic                    nRST,
   vector_elem_sequencer_if.slave bus
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t              state;
   logic [VL_WIDTH:0]   base, next_base;
   logic [VL_WIDTH-1:0] vl_q, vs;
   logic                run, done_q;
   assign run       = state == RUN;
   assign next_base = base + (VL_WIDTH+1)'(NUM_LANES);
`ifdef VSEQ_VSTART_EN
   logic [VL_WIDTH-1:0] exc_q;
   assign vs             = bus.vstart;
   assign bus.exc_vstart = exc_q;
   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) exc_q <= '0;
      else if (run && bus.trap && !bus.flush) exc_q <= base[VL_WIDTH-1:0];
`else
   assign vs             = '0;
   assign bus.exc_vstart = '0;
`endif
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= IDLE;
         base   <= '0;
         vl_q   <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.flush) state <= IDLE;
         else if (!run) begin
            if (bus.start) begin
               vl_q <= bus.vl;
               base <= {1'b0, vs};
               if (vs < bus.vl) state <= RUN;
               else done_q <= 1'b1;
            end
         end else if (bus.trap) state <= IDLE;
         else if (!bus.stall) begin
            base <= next_base;
            if (next_base >= {1'b0, vl_q}) begin
               state  <= IDLE;
               done_q <= 1'b1;
            end
         end
      end
   end
   assign bus.busy  = run;
   assign bus.valid = run;
   assign bus.done  = done_q;
   assign bus.last  = run && next_base >= {1'b0, vl_q};
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      logic [VL_WIDTH:0] idx;
      assign idx                                = base + (VL_WIDTH+1)'(i);
      assign bus.offset[i*VL_WIDTH +: VL_WIDTH] = run ? idx[VL_WIDTH-1:0] : '0;
      assign bus.lane_active[i]                 = run && idx < {1'b0, vl_q};
   end
endmodule
